// File: rtl/num2str_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : num2str_seq_if
// Description : Start/busy/done handshake and result bus for num2str_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface num2str_seq_if #(
    parameter int W   = 16,
    parameter int LEN = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [W-1:0]     d;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [8*LEN-1:0] str;

    modport master (output start, mode, d, input  busy, done, ovf, str);
    modport slave  (input  start, mode, d, output busy, done, ovf, str);
endinterface
`default_nettype wire

// File: rtl/num2str_seq.sv
`default_nettype none
// ============================================================================
// Module      : num2str_seq
// Description : Sequential binary/hex/decimal number-to-ASCII string builder.
// Revision    : 1.0 - initial release
// ============================================================================
module num2str_seq #(
    parameter int         W   = 16,
    parameter int         LEN = 16,
    parameter logic [7:0] PAD = 8'h2E
) (
    input  logic          clk,
    input  logic          rst,
    num2str_seq_if.slave  bus
);
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        do begin
            v = v / 64'd10;
            n++;
        end while (v != 0);
        return n;
    endfunction

    localparam int NDIG = dec_digits(W);
    localparam int NHEX = (W + 3) / 4;
    localparam int VW   = 4 * NHEX;
    localparam int SH   = (W > LEN) ? W : LEN;
    localparam int CW   = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic              r_neg;
    logic [VW-1:0]     r_val;
    logic [4*NDIG-1:0] r_bcd;
    logic [8*SH-1:0]   r_shadow;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_nd;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;
    logic [8*LEN-1:0]  r_str;

    logic              w_idle;
    logic [W-1:0]      w_abs;
    logic [1:0]        w_mode;
    logic              w_neg;
    logic [VW-1:0]     w_val;
    logic [VW-1:0]     w_nval;
    logic [4*NDIG-1:0] w_bcd;
    logic [4*NDIG-1:0] w_adj;
    logic [4*NDIG-1:0] w_nbcd;
    logic [8*SH-1:0]   w_nshadow;
    logic [3:0]        w_nib;
    int                w_step;
    int                w_nd;
    int                w_ndig;
    logic              w_last;
    logic              w_to_emit;
    logic              w_ovf;
    logic [8*LEN-1:0]  w_str;

    // The sampling cycle already performs the first step on the raw inputs,
    // so every cycle up to and including the done-setting edge does work.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_abs     = (bus.mode == 2'd3 && bus.d[W-1]) ? (~bus.d + W'(1)) : bus.d;
        w_mode    = w_idle ? bus.mode : r_mode;
        w_neg     = w_idle ? (bus.mode == 2'd3 && bus.d[W-1]) : r_neg;
        w_val     = w_idle ? VW'(w_abs) : r_val;
        w_bcd     = w_idle ? '0 : r_bcd;
        w_nd      = w_idle ? 0 : int'(r_nd);
        w_step    = w_idle ? 0 : int'(r_cnt);
        w_nval    = w_val;
        w_nbcd    = w_bcd;
        w_adj     = w_bcd;
        w_nshadow = r_shadow;
        w_nib     = '0;
        w_last    = 1'b0;
        w_to_emit = 1'b0;
        w_ndig    = 1;
        case (w_mode)
            2'd0: begin
                w_nshadow[8*w_step +: 8] = 8'h30 + {7'd0, w_val[0]};
                w_nval = w_val >> 1;
                w_last = (w_step == W - 1);
                w_ndig = W;
            end
            2'd1: begin
                w_nib = w_val[3:0];
                w_nshadow[8*w_step +: 8] = (w_nib < 4'd10) ? (8'h30 + {4'd0, w_nib})
                                                           : (8'h37 + {4'd0, w_nib});
                w_nval = w_val >> 4;
                w_last = (w_step == NHEX - 1);
                w_ndig = NHEX;
            end
            default: begin
                if (w_step < W) begin
                    for (int k = 0; k < NDIG; k++) begin
                        if (w_bcd[4*k +: 4] >= 4'd5)
                            w_adj[4*k +: 4] = w_bcd[4*k +: 4] + 4'd3;
                    end
                    w_nbcd    = {w_adj[4*NDIG-2:0], w_val[W-1]};
                    w_nval    = w_val << 1;
                    w_to_emit = (w_step == W - 1);
                end else begin
                    // Track the highest non-zero digit for leading-zero suppression.
                    w_nshadow[8*(w_step-W) +: 8] = 8'h30 + {4'd0, w_bcd[3:0]};
                    w_nbcd = w_bcd >> 4;
                    if (w_bcd[3:0] != 4'd0)
                        w_nd = w_step - W + 1;
                    w_last = (w_step == W + NDIG - 1);
                    w_ndig = (w_nd == 0) ? 1 : w_nd;
                end
            end
        endcase

        w_ovf = (w_ndig + (w_neg ? 1 : 0)) > LEN;
        w_str = '0;
        for (int i = 0; i < LEN; i++) begin
            if (w_ovf)
                w_str[8*i +: 8] = 8'h23;
            else if (i < w_ndig)
                w_str[8*i +: 8] = w_nshadow[8*i +: 8];
            else if (i == w_ndig && w_neg)
                w_str[8*i +: 8] = 8'h2D;
            else
                w_str[8*i +: 8] = PAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_neg    <= 1'b0;
            r_val    <= '0;
            r_bcd    <= '0;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_nd     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_str    <= {LEN{PAD}};
        end else if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
        end else if (!w_idle || bus.start) begin
            r_busy   <= 1'b1;
            r_val    <= w_nval;
            r_bcd    <= w_nbcd;
            r_shadow <= w_nshadow;
            r_nd     <= CW'(w_nd);
            r_cnt    <= CW'(w_step + 1);
            if (w_idle) begin
                r_mode  <= bus.mode;
                r_neg   <= w_neg;
                r_state <= S_CONV;
            end
            if (w_to_emit)
                r_state <= S_EMIT;
            if (w_last) begin
                r_str  <= w_str;
                r_ovf  <= w_ovf;
                r_done <= 1'b1;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.str  = r_str;
endmodule
`default_nettype wire

// File: tb/tb_num2str_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_num2str_seq
// Description : Self-checking bench for num2str_seq (LEN=16 and LEN=4 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_num2str_seq;
    localparam logic [127:0] PADS = {16{8'h2E}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] d = 16'd0;
    bit          chk = 1'b0;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    num2str_seq_if #(.W(16), .LEN(16)) bus16 ();
    num2str_seq_if #(.W(16), .LEN(4))  bus4 ();

    assign bus16.start = start;
    assign bus16.mode  = mode;
    assign bus16.d     = d;
    assign bus4.start  = start;
    assign bus4.mode   = mode;
    assign bus4.d      = d;

    num2str_seq #(.W(16), .LEN(16), .PAD(8'h2E)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    num2str_seq #(.W(16), .LEN(4),  .PAD(8'h2E)) dut4  (.clk(clk), .rst(rst), .bus(bus4));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int latency(input logic [1:0] m);
        if (m == 2'd0) return 16;
        if (m == 2'd1) return 4;
        return 21;
    endfunction

    // Formats the value with plain arithmetic, char 0 = least significant.
    function automatic logic [127:0] fmt(input logic [1:0] m, input logic [15:0] v,
                                         input int len, output bit o);
        logic [7:0]   ch [32];
        logic [127:0] hx;
        logic [127:0] r;
        int           n;
        int           nib;
        bit           neg;
        int unsigned  mag;
        hx  = "0123456789ABCDEF";
        n   = 0;
        neg = 1'b0;
        if (m == 2'd0) begin
            for (int i = 0; i < 16; i++) ch[i] = v[i] ? 8'h31 : 8'h30;
            n = 16;
        end else if (m == 2'd1) begin
            for (int i = 0; i < 4; i++) begin
                nib   = int'((v >> (4*i)) & 16'hF);
                ch[i] = hx[8*(15-nib) +: 8];
            end
            n = 4;
        end else begin
            neg = (m == 2'd3) && v[15];
            mag = neg ? (32'd65536 - 32'(v)) : 32'(v);
            do begin
                ch[n] = 8'h30 + 8'(mag % 10);
                mag   = mag / 10;
                n++;
            end while (mag != 0);
        end
        o = (n + (neg ? 1 : 0)) > len;
        r = PADS;
        for (int i = 0; i < len; i++) begin
            if (o)                r[8*i +: 8] = 8'h23;
            else if (i < n)       r[8*i +: 8] = ch[i];
            else if (i == n && neg) r[8*i +: 8] = 8'h2D;
            else                  r[8*i +: 8] = 8'h2E;
        end
        return r;
    endfunction

    // Cycle-level model: index 0 tracks the LEN=16 copy, index 1 the LEN=4 copy.
    int           cyc [2];
    int           lat [2];
    logic [127:0] pend [2];
    bit           pend_ovf [2];
    logic [127:0] exp_str [2];
    bit           exp_ovf [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit o;
            if (rst) begin
                cyc[k]     = 0;
                exp_str[k] = PADS;
                exp_ovf[k] = 1'b0;
            end else if (cyc[k] == 0) begin
                if (start) begin
                    cyc[k]      = 1;
                    lat[k]      = latency(mode);
                    pend[k]     = fmt(mode, d, (k == 0) ? 16 : 4, o);
                    pend_ovf[k] = o;
                end
            end else if (cyc[k] == lat[k]) begin
                cyc[k] = 0;
            end else begin
                cyc[k] = cyc[k] + 1;
                if (cyc[k] == lat[k]) begin
                    exp_str[k] = pend[k];
                    exp_ovf[k] = pend_ovf[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("busy16", 128'(bus16.busy), 128'(cyc[0] != 0));
            check("done16", 128'(bus16.done), 128'(cyc[0] != 0 && cyc[0] == lat[0]));
            check("ovf16",  128'(bus16.ovf),  128'(exp_ovf[0]));
            check("str16",  bus16.str,        exp_str[0]);
            check("busy4",  128'(bus4.busy),  128'(cyc[1] != 0));
            check("done4",  128'(bus4.done),  128'(cyc[1] != 0 && cyc[1] == lat[1]));
            check("ovf4",   128'(bus4.ovf),   128'(exp_ovf[1]));
            check("str4",   128'(bus4.str),   128'(exp_str[1][31:0]));
        end
    end

    task automatic conv(input logic [1:0] m, input logic [15:0] v,
                        input logic [127:0] lit16, input logic [31:0] lit4,
                        input bit lit_ovf4, input int lit_lat, input bit poke);
        int k;
        int extra;
        bit seen;
        @(negedge clk);
        start = 1'b1; mode = m; d = v;
        @(negedge clk);
        start = 1'b0;
        if (poke) d = ~v;
        k    = 1;
        seen = 1'b0;
        while (!seen && k < 200) begin
            if (poke && k == 3) start = 1'b1;
            if (poke && k == 4) start = 1'b0;
            if (bus16.done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("latency", 128'(k), 128'(lit_lat));
        check("lit_str16", bus16.str, lit16);
        check("lit_str4", 128'(bus4.str), 128'(lit4));
        check("lit_ovf4", 128'(bus4.ovf), 128'(lit_ovf4));
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            extra = 0;
            repeat (25) begin
                @(negedge clk);
                if (bus16.done) extra++;
            end
            check("extra_done", 128'(extra), 128'(0));
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk = 1'b1;
        check("reset_str", bus16.str, PADS);
        check("reset_busy", 128'(bus16.busy), 128'(0));
        check("reset_done", 128'(bus16.done), 128'(0));
        rst = 1'b0;

        // Abort a decimal conversion part-way through.
        @(negedge clk);
        start = 1'b1; mode = 2'd2; d = 16'd65535;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_str", bus16.str, PADS);
        check("abort_busy", 128'(bus16.busy), 128'(0));

        conv(2'd0, 16'hA5A5, "1010010110100101", "####", 1'b1, 16, 1'b0);
        conv(2'd1, 16'h00BE, "............00BE", "00BE", 1'b0, 4, 1'b0);
        conv(2'd1, 16'h1F0A, "............1F0A", "1F0A", 1'b0, 4, 1'b0);
        conv(2'd2, 16'd65535, "...........65535", "####", 1'b1, 21, 1'b0);
        conv(2'd2, 16'd0, "...............0", "...0", 1'b0, 21, 1'b0);
        conv(2'd3, 16'h8000, "..........-32768", "####", 1'b1, 21, 1'b1);
        conv(2'd3, 16'hFFFF, "..............-1", "..-1", 1'b0, 21, 1'b0);
        conv(2'd3, 16'hFFD6, ".............-42", ".-42", 1'b0, 21, 1'b0);
        conv(2'd2, 16'd12345, "...........12345", "####", 1'b1, 21, 1'b0);
        conv(2'd2, 16'd42, "..............42", "..42", 1'b0, 21, 1'b0);
        conv(2'd3, 16'd42, "..............42", "..42", 1'b0, 21, 1'b0);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
